// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch-address generator and its branch target buffer.
package pc_pkg;
  localparam int ADDR_BUS = 32;
  localparam logic [ADDR_BUS-1:0] INIT_PC_DEF = 32'hbfc0_0000;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  // Tag and target are sized to the full bus; narrower configurations use the low bits.
  typedef struct packed {
    logic                valid;
    logic [ADDR_BUS-1:0] tag;
    logic [ADDR_BUS-1:0] target;
    ctr_e                ctr;
  } btb_entry_t;

  function automatic ctr_e ctr_next(input ctr_e cur, input logic taken);
    ctr_e nxt;
    nxt = cur;
    case (cur)
      CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  nxt = taken ? CTR_ST  : CTR_WT;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction
endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: combinational lookup, registered update,
// synchronous clear of the valid bits.
module pc_btb
  import pc_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:2] lookup_pc_i,
  output logic                  hit_taken_o,
  output logic [ADDR_WIDTH-1:0] target_o,
  input  logic                  upd_en_i,
  input  logic [ADDR_WIDTH-1:2] upd_pc_i,
  input  logic [ADDR_WIDTH-1:0] upd_target_i,
  input  logic                  upd_taken_i
);
  localparam int IDX   = $clog2(DEPTH);
  localparam int TAG_W = ADDR_WIDTH - IDX - 2;

  btb_entry_t mem_q [DEPTH];

  logic [IDX-1:0]   rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  btb_entry_t       rd_e, wr_e;
  logic             wr_hit;

  assign rd_idx = lookup_pc_i[IDX+1:2];
  assign rd_tag = lookup_pc_i[ADDR_WIDTH-1:IDX+2];
  assign wr_idx = upd_pc_i[IDX+1:2];
  assign wr_tag = upd_pc_i[ADDR_WIDTH-1:IDX+2];
  assign rd_e   = mem_q[rd_idx];
  assign wr_e   = mem_q[wr_idx];
  assign wr_hit = wr_e.valid && (wr_e.tag == ADDR_BUS'(wr_tag));

  assign hit_taken_o = rd_e.valid && (rd_e.tag == ADDR_BUS'(rd_tag))
                       && ((rd_e.ctr == CTR_WT) || (rd_e.ctr == CTR_ST));
  assign target_o    = rd_e.target[ADDR_WIDTH-1:0];

  // Lookup reads mem_q directly, so a same-index update is only visible after the edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i].valid <= 1'b0;
    end else if (upd_en_i) begin
      if (wr_hit) begin
        mem_q[wr_idx].ctr <= ctr_next(wr_e.ctr, upd_taken_i);
        if (upd_taken_i) mem_q[wr_idx].target <= ADDR_BUS'(upd_target_i);
      end else if (upd_taken_i) begin
        mem_q[wr_idx] <= '{valid:  1'b1,
                           tag:    ADDR_BUS'(wr_tag),
                           target: ADDR_BUS'(upd_target_i),
                           ctr:    CTR_WT};
      end
    end
  end
endmodule

// File: rtl/pc_gen.sv
// IF-stage fetch PC: next-PC priority mux, pending-redirect register, start-up
// gating and the ROM request, with a BTB for taken-branch prediction.
module pc_gen
  import pc_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] INIT_PC    = ADDR_WIDTH'(INIT_PC_DEF),
  parameter int                    BTB_DEPTH  = 16,
  parameter bit                    BTB_EN     = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic [ADDR_WIDTH-1:0] exc_pc_i,
  input  logic                  stall_pc_i,
  input  logic                  branch_flag_i,
  input  logic [ADDR_WIDTH-1:0] branch_addr_i,
  input  logic                  btb_upd_en_i,
  input  logic [ADDR_WIDTH-1:0] btb_upd_pc_i,
  input  logic [ADDR_WIDTH-1:0] btb_upd_target_i,
  input  logic                  btb_upd_taken_i,
  input  logic                  rom_ready_i,
  output logic                  rom_en_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  output logic [3:0]            rom_write_en_o,
  output logic [31:0]           rom_write_data_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  pc_valid_o,
  output logic                  pred_taken_o,
  output logic [ADDR_WIDTH-1:0] pred_target_o
);
  logic                  started_q, pc_valid_q, pend_v_q;
  logic [ADDR_WIDTH-1:0] pc_q, pend_addr_q, pc_d;
  logic                  flush_eff, branch_eff, adv, btb_hit;
  logic [ADDR_WIDTH-1:0] btb_target;
  logic                  unused_upd_lsb;

  assign unused_upd_lsb = ^btb_upd_pc_i[1:0];

  pc_btb #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(BTB_DEPTH)) u_btb (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .lookup_pc_i  (pc_q[ADDR_WIDTH-1:2]),
    .hit_taken_o  (btb_hit),
    .target_o     (btb_target),
    .upd_en_i     (BTB_EN && started_q && btb_upd_en_i),
    .upd_pc_i     (btb_upd_pc_i[ADDR_WIDTH-1:2]),
    .upd_target_i (btb_upd_target_i),
    .upd_taken_i  (btb_upd_taken_i)
  );

  assign flush_eff  = started_q && flush_i;
  assign branch_eff = started_q && branch_flag_i;
  assign adv        = started_q && rom_ready_i && (flush_i || !stall_pc_i);

  assign pred_taken_o  = BTB_EN && pc_valid_q && btb_hit;
  assign pred_target_o = btb_target;

  always_comb begin
    pc_d = pc_q + ADDR_WIDTH'(4);
    if (flush_eff)         pc_d = exc_pc_i;
    else if (branch_eff)   pc_d = branch_addr_i;
    else if (pend_v_q)     pc_d = pend_addr_q;
    else if (stall_pc_i)   pc_d = pc_q;
    else if (pred_taken_o) pc_d = btb_target;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      started_q   <= 1'b0;
      pc_q        <= INIT_PC - ADDR_WIDTH'(4);
      pc_valid_q  <= 1'b0;
      pend_v_q    <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      started_q <= 1'b1;
      if (adv) begin
        pc_q       <= pc_d;
        pc_valid_q <= 1'b1;
      end
      // A flush blocked by ROM backpressure parks its target like a branch would.
      if (flush_eff) begin
        pend_v_q <= !adv;
        if (!adv) pend_addr_q <= exc_pc_i;
      end else if (branch_eff && !adv) begin
        pend_v_q    <= 1'b1;
        pend_addr_q <= branch_addr_i;
      end else if (adv) begin
        pend_v_q <= 1'b0;
      end
    end
  end

  assign rom_en_o         = started_q;
  assign rom_addr_o       = pc_d;
  assign rom_write_en_o   = 4'b0;
  assign rom_write_data_o = 32'b0;
  assign pc_o             = pc_q;
  assign pc_valid_o       = pc_valid_q;
endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: start-up, stalls, redirects, backpressure, BTB and wrap.
module tb_pc_gen;
  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, stall_pc_i, branch_flag_i;
  logic [31:0] exc_pc_i, branch_addr_i, btb_upd_pc_i, btb_upd_target_i;
  logic        btb_upd_en_i, btb_upd_taken_i, rom_ready_i;
  logic        rom_en_o, pc_valid_o, pred_taken_o;
  logic [31:0] rom_addr_o, pc_o, pred_target_o, rom_write_data_o;
  logic [3:0]  rom_write_en_o;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  pc_gen dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .exc_pc_i(exc_pc_i),
    .stall_pc_i(stall_pc_i), .branch_flag_i(branch_flag_i), .branch_addr_i(branch_addr_i),
    .btb_upd_en_i(btb_upd_en_i), .btb_upd_pc_i(btb_upd_pc_i),
    .btb_upd_target_i(btb_upd_target_i), .btb_upd_taken_i(btb_upd_taken_i),
    .rom_ready_i(rom_ready_i), .rom_en_o(rom_en_o), .rom_addr_o(rom_addr_o),
    .rom_write_en_o(rom_write_en_o), .rom_write_data_o(rom_write_data_o),
    .pc_o(pc_o), .pc_valid_o(pc_valid_o), .pred_taken_o(pred_taken_o),
    .pred_target_o(pred_target_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1; flush_i = 0; stall_pc_i = 0; branch_flag_i = 0; rom_ready_i = 1;
    exc_pc_i = 0; branch_addr_i = 0; btb_upd_en_i = 0; btb_upd_pc_i = 0;
    btb_upd_target_i = 0; btb_upd_taken_i = 0;
    tick(); tick(); tick();
    n_cmp++; if (pc_o !== 32'hbfbf_fffc) begin n_err++; $display("FAIL reset_pc got %h want bfbffffc", pc_o); end
    n_cmp++; if (pc_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_pc_valid got %b want 0", pc_valid_o); end
    n_cmp++; if (rom_en_o !== 1'b0) begin n_err++; $display("FAIL reset_rom_en got %b want 0", rom_en_o); end
    n_cmp++; if (pred_taken_o !== 1'b0) begin n_err++; $display("FAIL reset_pred got %b want 0", pred_taken_o); end
    n_cmp++; if (rom_write_en_o !== 4'h0 || rom_write_data_o !== 32'h0) begin n_err++; $display("FAIL rom_write got %h/%h want 0/0", rom_write_en_o, rom_write_data_o); end
  endtask

  task automatic test_startup();
    rst_i = 0; #1;
    n_cmp++; if (rom_en_o !== 1'b0) begin n_err++; $display("FAIL start_c0_rom_en got %b want 0", rom_en_o); end
    tick();
    n_cmp++; if (rom_en_o !== 1'b1 || rom_addr_o !== 32'hbfc0_0000) begin n_err++; $display("FAIL start_c1 got en=%b addr=%h want 1 bfc00000", rom_en_o, rom_addr_o); end
    n_cmp++; if (pc_valid_o !== 1'b0) begin n_err++; $display("FAIL start_c1_valid got %b want 0", pc_valid_o); end
    tick();
    n_cmp++; if (pc_o !== 32'hbfc0_0000 || pc_valid_o !== 1'b1) begin n_err++; $display("FAIL start_c2_pc got %h/%b want bfc00000/1", pc_o, pc_valid_o); end
    n_cmp++; if (rom_addr_o !== 32'hbfc0_0004) begin n_err++; $display("FAIL start_c2_addr got %h want bfc00004", rom_addr_o); end
    tick();
    n_cmp++; if (pc_o !== 32'hbfc0_0004 || rom_addr_o !== 32'hbfc0_0008) begin n_err++; $display("FAIL start_c3 got pc=%h addr=%h want bfc00004 bfc00008", pc_o, rom_addr_o); end
  endtask

  task automatic test_branch_stall();
    stall_pc_i = 1; branch_flag_i = 1; branch_addr_i = 32'hbfc0_0100; #1;
    n_cmp++; if (rom_addr_o !== 32'hbfc0_0100) begin n_err++; $display("FAIL bstall_comb got %h want bfc00100", rom_addr_o); end
    tick();
    branch_flag_i = 0; #1;
    n_cmp++; if (pc_o !== 32'hbfc0_0004 || rom_addr_o !== 32'hbfc0_0100) begin n_err++; $display("FAIL bstall_hold got pc=%h addr=%h want bfc00004 bfc00100", pc_o, rom_addr_o); end
    tick(); tick();
    n_cmp++; if (pc_o !== 32'hbfc0_0004) begin n_err++; $display("FAIL bstall_hold3 got %h want bfc00004", pc_o); end
    stall_pc_i = 0; #1;
    n_cmp++; if (rom_addr_o !== 32'hbfc0_0100) begin n_err++; $display("FAIL bstall_release got %h want bfc00100", rom_addr_o); end
    tick();
    n_cmp++; if (pc_o !== 32'hbfc0_0100 || rom_addr_o !== 32'hbfc0_0104) begin n_err++; $display("FAIL bstall_after got pc=%h addr=%h want bfc00100 bfc00104", pc_o, rom_addr_o); end
  endtask

  task automatic test_flush_priority();
    stall_pc_i = 1; branch_flag_i = 1; branch_addr_i = 32'hbfc0_0500;
    tick();
    flush_i = 1; exc_pc_i = 32'hbfc0_0380; branch_addr_i = 32'hbfc0_0600; #1;
    n_cmp++; if (rom_addr_o !== 32'hbfc0_0380) begin n_err++; $display("FAIL flush_comb got %h want bfc00380", rom_addr_o); end
    tick();
    flush_i = 0; branch_flag_i = 0; stall_pc_i = 0; #1;
    n_cmp++; if (pc_o !== 32'hbfc0_0380 || rom_addr_o !== 32'hbfc0_0384) begin n_err++; $display("FAIL flush_after got pc=%h addr=%h want bfc00380 bfc00384", pc_o, rom_addr_o); end
    tick();
    n_cmp++; if (pc_o !== 32'hbfc0_0384) begin n_err++; $display("FAIL flush_seq got %h want bfc00384", pc_o); end
  endtask

  task automatic test_backpressure();
    rom_ready_i = 0; #1;
    n_cmp++; if (rom_addr_o !== 32'hbfc0_0388) begin n_err++; $display("FAIL bp_addr0 got %h want bfc00388", rom_addr_o); end
    tick();
    n_cmp++; if (pc_o !== 32'hbfc0_0384 || rom_addr_o !== 32'hbfc0_0388) begin n_err++; $display("FAIL bp_hold got pc=%h addr=%h want bfc00384 bfc00388", pc_o, rom_addr_o); end
    flush_i = 1; exc_pc_i = 32'hbfc0_0200; #1;
    n_cmp++; if (rom_addr_o !== 32'hbfc0_0200) begin n_err++; $display("FAIL bp_flush_comb got %h want bfc00200", rom_addr_o); end
    tick();
    flush_i = 0; #1;
    n_cmp++; if (pc_o !== 32'hbfc0_0384 || rom_addr_o !== 32'hbfc0_0200) begin n_err++; $display("FAIL bp_pend got pc=%h addr=%h want bfc00384 bfc00200", pc_o, rom_addr_o); end
    tick();
    rom_ready_i = 1; #1;
    tick();
    n_cmp++; if (pc_o !== 32'hbfc0_0200 || rom_addr_o !== 32'hbfc0_0204) begin n_err++; $display("FAIL bp_apply got pc=%h addr=%h want bfc00200 bfc00204", pc_o, rom_addr_o); end
  endtask

  task automatic test_btb();
    btb_upd_en_i = 1; btb_upd_pc_i = 32'hbfc0_0010; btb_upd_target_i = 32'hbfc0_0040; btb_upd_taken_i = 1;
    tick();
    btb_upd_en_i = 0; branch_flag_i = 1; branch_addr_i = 32'hbfc0_0010;
    tick();
    branch_flag_i = 0; #1;
    n_cmp++; if (pc_o !== 32'hbfc0_0010 || pred_taken_o !== 1'b1) begin n_err++; $display("FAIL btb_pred got pc=%h pred=%b want bfc00010 1", pc_o, pred_taken_o); end
    n_cmp++; if (pred_target_o !== 32'hbfc0_0040 || rom_addr_o !== 32'hbfc0_0040) begin n_err++; $display("FAIL btb_target got tgt=%h addr=%h want bfc00040", pred_target_o, rom_addr_o); end
    tick();
    n_cmp++; if (pc_o !== 32'hbfc0_0040 || pred_taken_o !== 1'b0 || rom_addr_o !== 32'hbfc0_0044) begin n_err++; $display("FAIL btb_follow got pc=%h pred=%b addr=%h want bfc00040 0 bfc00044", pc_o, pred_taken_o, rom_addr_o); end
    branch_flag_i = 1; branch_addr_i = 32'hbfc0_0050;
    tick();
    branch_flag_i = 0; #1;
    n_cmp++; if (pc_o !== 32'hbfc0_0050 || pred_taken_o !== 1'b0 || rom_addr_o !== 32'hbfc0_0054) begin n_err++; $display("FAIL btb_alias got pc=%h pred=%b addr=%h want bfc00050 0 bfc00054", pc_o, pred_taken_o, rom_addr_o); end
    branch_flag_i = 1; branch_addr_i = 32'hbfc0_0010;
    tick();
    branch_flag_i = 0; stall_pc_i = 1; btb_upd_en_i = 1; btb_upd_taken_i = 1;
    tick();
    btb_upd_taken_i = 0;
    tick();
    btb_upd_en_i = 0; #1;
    n_cmp++; if (pred_taken_o !== 1'b1 || rom_addr_o !== 32'hbfc0_0010) begin n_err++; $display("FAIL btb_one_nt got pred=%b addr=%h want 1 bfc00010", pred_taken_o, rom_addr_o); end
    btb_upd_en_i = 1; #1;
    n_cmp++; if (pred_taken_o !== 1'b1) begin n_err++; $display("FAIL btb_same_cycle got pred=%b want 1", pred_taken_o); end
    tick();
    btb_upd_en_i = 0; #1;
    n_cmp++; if (pred_taken_o !== 1'b0) begin n_err++; $display("FAIL btb_two_nt got pred=%b want 0", pred_taken_o); end
    stall_pc_i = 0; #1;
    n_cmp++; if (rom_addr_o !== 32'hbfc0_0014) begin n_err++; $display("FAIL btb_seq got %h want bfc00014", rom_addr_o); end
  endtask

  task automatic test_wrap();
    branch_flag_i = 1; branch_addr_i = 32'hffff_fffc;
    tick();
    branch_flag_i = 0; #1;
    n_cmp++; if (pc_o !== 32'hffff_fffc || rom_addr_o !== 32'h0) begin n_err++; $display("FAIL wrap got pc=%h addr=%h want fffffffc 0", pc_o, rom_addr_o); end
    tick();
    n_cmp++; if (pc_o !== 32'h0) begin n_err++; $display("FAIL wrap_pc got %h want 0", pc_o); end
  endtask

  task automatic test_reset_midop();
    stall_pc_i = 1; branch_flag_i = 1; branch_addr_i = 32'hbfc0_0700;
    tick();
    branch_flag_i = 0; rst_i = 1;
    tick();
    n_cmp++; if (pc_o !== 32'hbfbf_fffc || pc_valid_o !== 1'b0 || rom_en_o !== 1'b0 || pred_taken_o !== 1'b0) begin n_err++; $display("FAIL midrst got pc=%h v=%b en=%b pred=%b want bfbffffc 0 0 0", pc_o, pc_valid_o, rom_en_o, pred_taken_o); end
    rst_i = 0; stall_pc_i = 0; branch_flag_i = 1; branch_addr_i = 32'hbfc0_0900; #1;
    n_cmp++; if (rom_en_o !== 1'b0 || rom_addr_o !== 32'hbfc0_0000) begin n_err++; $display("FAIL midrst_c0 got en=%b addr=%h want 0 bfc00000", rom_en_o, rom_addr_o); end
    tick();
    branch_flag_i = 0; #1;
    n_cmp++; if (rom_en_o !== 1'b1 || rom_addr_o !== 32'hbfc0_0000) begin n_err++; $display("FAIL midrst_c1 got en=%b addr=%h want 1 bfc00000", rom_en_o, rom_addr_o); end
    tick();
    n_cmp++; if (pc_o !== 32'hbfc0_0000 || pc_valid_o !== 1'b1) begin n_err++; $display("FAIL midrst_c2 got pc=%h v=%b want bfc00000 1", pc_o, pc_valid_o); end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_branch_stall();
    test_flush_priority();
    test_backpressure();
    test_btb();
    test_wrap();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
